// File: rtl/hsv_ctrl_pkg.sv
// Shared types and default constants for the HSV stream controller.
// Imported by the FIFO, the stream interface and the top level.
package hsv_ctrl_pkg;

   localparam int PIPE_LAT_DEF   = 3;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int DIM_W_DEF      = 12;
   localparam int PIX_W          = 27;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } ctrl_state_e;

   typedef struct packed {
      logic sof;
      logic eol;
   } pix_tag_t;

   typedef struct packed {
      logic [8:0] h;
      logic [7:0] s;
      logic [7:0] v;
      logic       sof;
      logic       eol;
   } hsv_pix_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

endpackage

// File: rtl/hsv_stream_ctrl_if.sv
// Valid/ready stream of tagged HSV pixels.
// The buffer drives it as master; the consumer side is the slave.
interface hsv_stream_ctrl_if;
   import hsv_ctrl_pkg::*;

   logic     valid;
   logic     ready;
   hsv_pix_t data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/hsv_ctrl_fifo.sv
// Show-ahead synchronous output buffer for tagged HSV pixels.
// The head is presented combinationally; empty reads are masked to zero.
module hsv_ctrl_fifo
   import hsv_ctrl_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  hsv_pix_t          wr_data,
   output logic [CW-1:0]     count,
   hsv_stream_ctrl_if.master rd
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   hsv_pix_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            rd_en;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rd_en    = rd.ready && (cnt != '0);
   assign count    = cnt;
   assign rd.valid = (cnt != '0);
   assign rd.data  = rd.valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= bump(wr_ptr);
         if (rd_en) rd_ptr <= bump(rd_ptr);
         unique case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/hsv_stream_ctrl.sv
// Frame controller feeding an external HSV converter and buffering its output.
// Define HSV_CTRL_STATS_EN to build the pixel/stall statistics counters.
module hsv_stream_ctrl
   import hsv_ctrl_pkg::*;
#(
   parameter int PIPE_LAT   = PIPE_LAT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int DIM_W      = DIM_W_DEF
) (
   input  logic             clk_Image_Process,
   input  logic             Rst,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_width,
   input  logic [DIM_W-1:0] cfg_height,
   output logic             busy,
   output logic             frame_done,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_r,
   input  logic [7:0]       s_g,
   input  logic [7:0]       s_b,
   output logic [7:0]       cvt_r,
   output logic [7:0]       cvt_g,
   output logic [7:0]       cvt_b,
   input  logic [8:0]       cvt_h,
   input  logic [7:0]       cvt_s,
   input  logic [7:0]       cvt_v,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [8:0]       m_h,
   output logic [7:0]       m_s,
   output logic [7:0]       m_v,
   output logic             m_sof,
   output logic             m_eol,
   output logic [31:0]      stat_pix,
   output logic [31:0]      stat_stall
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(PIPE_LAT + 2);

   ctrl_state_e       state_q;
   ctrl_state_e       state_d;
   logic              done_d;
   logic              frame_done_q;
   logic [DIM_W-1:0]  w_q;
   logic [DIM_W-1:0]  h_q;
   logic [DIM_W-1:0]  x_q;
   logic [DIM_W-1:0]  y_q;
   logic [7:0]        r_q;
   logic [7:0]        g_q;
   logic [7:0]        b_q;
   logic              acc_vld_q;
   pix_tag_t          acc_tag_q;
   logic [PIPE_LAT-1:0] vld_q;
   pix_tag_t          tag_q [PIPE_LAT];
   logic [CW-1:0]     fifo_cnt;
   logic [IW-1:0]     infl;
   logic              start_ok;
   logic              accept;
   logic              last_x;
   logic              last_pix;
   logic              wr_en;
   hsv_pix_t          wr_data;

   hsv_stream_ctrl_if m_if ();

   assign start_ok = (state_q == IDLE) && start
                   && (cfg_width != '0) && (cfg_height != '0);
   assign last_x   = (x_q == w_q - 1'b1);
   assign last_pix = last_x && (y_q == h_q - 1'b1);
   assign accept   = s_valid && s_ready;
   assign busy     = (state_q != IDLE);
   assign frame_done = frame_done_q;

   // Pixels between the input register and the FIFO write port.
   always_comb begin
      infl = IW'(acc_vld_q);
      for (int i = 0; i < PIPE_LAT; i++) begin
         infl = infl + IW'(vld_q[i]);
      end
   end

   // Credit: reserve a FIFO slot for every pixel still in the converter.
   assign s_ready = (state_q == RUN)
                  && ((int'(fifo_cnt) + int'(infl)) < FIFO_DEPTH);

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE:  if (start_ok) state_d = RUN;
         RUN:   if (accept && last_pix) state_d = DRAIN;
         DRAIN: begin
            if ((infl == '0) && (fifo_cnt == '0)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_Image_Process) begin
      if (!Rst) begin
         state_q      <= IDLE;
         frame_done_q <= 1'b0;
         w_q          <= '0;
         h_q          <= '0;
         x_q          <= '0;
         y_q          <= '0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= done_d;
         if (start_ok) begin
            w_q <= cfg_width;
            h_q <= cfg_height;
            x_q <= '0;
            y_q <= '0;
         end else if (accept) begin
            if (last_x) begin
               x_q <= '0;
               y_q <= y_q + 1'b1;
            end else begin
               x_q <= x_q + 1'b1;
            end
         end
      end
   end

   // Tags ride alongside the converter so they meet its result at the FIFO.
   always_ff @(posedge clk_Image_Process) begin
      if (!Rst) begin
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         acc_vld_q <= 1'b0;
         acc_tag_q <= '0;
         vld_q     <= '0;
         for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
      end else begin
         acc_vld_q <= accept;
         if (accept) begin
            r_q       <= s_r;
            g_q       <= s_g;
            b_q       <= s_b;
            acc_tag_q <= '{sof: (x_q == '0) && (y_q == '0), eol: last_x};
         end
         vld_q[0] <= acc_vld_q;
         tag_q[0] <= acc_tag_q;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign cvt_r   = r_q;
   assign cvt_g   = g_q;
   assign cvt_b   = b_q;
   assign wr_en   = vld_q[PIPE_LAT-1];
   assign wr_data = '{h:   cvt_h,
                      s:   cvt_s,
                      v:   cvt_v,
                      sof: tag_q[PIPE_LAT-1].sof,
                      eol: tag_q[PIPE_LAT-1].eol};

   hsv_ctrl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk_Image_Process),
      .rst_n   (Rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .count   (fifo_cnt),
      .rd      (m_if.master)
   );

   assign m_if.ready = m_ready;
   assign m_valid    = m_if.valid;
   assign m_h        = m_if.data.h;
   assign m_s        = m_if.data.s;
   assign m_v        = m_if.data.v;
   assign m_sof      = m_if.data.sof;
   assign m_eol      = m_if.data.eol;

`ifdef HSV_CTRL_STATS_EN
   logic [31:0] pix_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk_Image_Process) begin
      if (!Rst || start_ok) begin
         pix_q   <= '0;
         stall_q <= '0;
      end else begin
         if (m_valid && m_ready) pix_q <= sat_inc(pix_q);
         if ((state_q == RUN) && s_valid && !s_ready) begin
            stall_q <= sat_inc(stall_q);
         end
      end
   end

   assign stat_pix   = pix_q;
   assign stat_stall = stall_q;
`else
   assign stat_pix   = '0;
   assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_hsv_stream_ctrl.sv
// Directed scoreboard bench for hsv_stream_ctrl with a 3-cycle HSV model.
// The buffer is sized at its minimum so credit stalls can be provoked.
module tb_hsv_stream_ctrl;
   import hsv_ctrl_pkg::*;

   localparam int PL = 3;
   localparam int FD = 5;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] cw = '0;
   logic [DW-1:0] ch = '0;
   logic          busy;
   logic          frame_done;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [7:0]    s_r = '0;
   logic [7:0]    s_g = '0;
   logic [7:0]    s_b = '0;
   logic [7:0]    cvt_r;
   logic [7:0]    cvt_g;
   logic [7:0]    cvt_b;
   logic [8:0]    cvt_h;
   logic [7:0]    cvt_s;
   logic [7:0]    cvt_v;
   logic [8:0]    m_h;
   logic [7:0]    m_s;
   logic [7:0]    m_v;
   logic          m_sof;
   logic          m_eol;
   logic [31:0]   stat_pix;
   logic [31:0]   stat_stall;

   hsv_stream_ctrl_if mif ();

   int n_chk = 0;
   int n_fail = 0;
   int acc_n = 0;
   int out_n = 0;
   int fd_n = 0;
   int stall_n = 0;
   int mx = 0;
   int my = 0;
   int ew = 1;
   hsv_pix_t q[$];

   always #5 clk = ~clk;

   hsv_stream_ctrl #(
      .PIPE_LAT   (PL),
      .FIFO_DEPTH (FD),
      .DIM_W      (DW)
   ) dut (
      .clk_Image_Process (clk),
      .Rst        (rst),
      .start      (start),
      .cfg_width  (cw),
      .cfg_height (ch),
      .busy       (busy),
      .frame_done (frame_done),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_r        (s_r),
      .s_g        (s_g),
      .s_b        (s_b),
      .cvt_r      (cvt_r),
      .cvt_g      (cvt_g),
      .cvt_b      (cvt_b),
      .cvt_h      (cvt_h),
      .cvt_s      (cvt_s),
      .cvt_v      (cvt_v),
      .m_valid    (mif.valid),
      .m_ready    (mif.ready),
      .m_h        (m_h),
      .m_s        (m_s),
      .m_v        (m_v),
      .m_sof      (m_sof),
      .m_eol      (m_eol),
      .stat_pix   (stat_pix),
      .stat_stall (stat_stall)
   );

   function automatic logic [24:0] rgb2hsv(input logic [7:0] r8, g8, b8);
      int r, g, b, mxv, mnv, d, h, s;
      r = int'(r8); g = int'(g8); b = int'(b8);
      mxv = (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
      mnv = (r < g) ? ((r < b) ? r : b) : ((g < b) ? g : b);
      d = mxv - mnv;
      s = (mxv == 0) ? 0 : (d * 255) / mxv;
      if (d == 0) h = 0;
      else if (mxv == r) h = (60 * (g - b)) / d;
      else if (mxv == g) h = 120 + (60 * (b - r)) / d;
      else h = 240 + (60 * (r - g)) / d;
      if (h < 0) h = h + 360;
      return {9'(h), 8'(s), 8'(mxv)};
   endfunction

   // Free-running converter model: three register stages.
   logic [24:0] cp1 = '0, cp2 = '0, cp3 = '0;
   always @(posedge clk) begin
      cp1 <= rgb2hsv(cvt_r, cvt_g, cvt_b);
      cp2 <= cp1;
      cp3 <= cp2;
   end
   assign {cvt_h, cvt_s, cvt_v} = cp3;

   task automatic chk(input string tag, input logic [63:0] obs, exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      hsv_pix_t e;
      if (!rst) begin
         q.delete();
         mx = 0;
         my = 0;
      end else begin
         if (start && !busy && cw != 0 && ch != 0) begin
            mx = 0;
            my = 0;
            ew = int'(cw);
         end
         if (s_valid && s_ready) begin
            q.push_back({rgb2hsv(s_r, s_g, s_b), (mx == 0 && my == 0),
                         (mx == ew - 1)});
            acc_n++;
            if (mx == ew - 1) begin
               mx = 0;
               my++;
            end else mx++;
         end
         if (busy && s_valid && !s_ready) stall_n++;
         if (mif.valid && mif.ready) begin
            if (q.size() == 0) chk("sb_unexpected_out", 1, 0);
            else begin
               e = q.pop_front();
               chk("sb_pix", {m_h, m_s, m_v, m_sof, m_eol}, e);
            end
            out_n++;
         end
         if (frame_done) fd_n++;
      end
   end

   function automatic logic [23:0] pix(input int i, input int seed);
      return {8'(i * 53 + seed), 8'(i * 97 + 3 * seed), 8'(i * 29 + 200)};
   endfunction

   task automatic send_pix(input logic [23:0] rgb);
      int n;
      logic rdy;
      n = 0;
      s_valid = 1'b1;
      {s_r, s_g, s_b} = rgb;
      forever begin
         @(negedge clk);
         rdy = s_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 300) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input int n, input int seed);
      for (int i = 0; i < n; i++) send_pix(pix(i, seed));
   endtask

   task automatic start_frame(input int w, input int h);
      cw = DW'(w);
      ch = DW'(h);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!frame_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(tag, frame_done, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fd0, o0, a0, s0, n;
      logic [26:0] head;
      logic have_head;
      mif.ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", mif.valid, 0);
      chk("rst_m_bus", {m_h, m_s, m_v, m_sof, m_eol}, 0);
      chk("rst_cvt", {cvt_r, cvt_g, cvt_b}, 0);
      chk("rst_stats", {stat_pix, stat_stall}, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      start_frame(0, 3);
      chk("zero_w_busy", busy, 0);
      start_frame(4, 0);
      chk("zero_h_busy", busy, 0);
      chk("zero_dim_s_ready", s_ready, 0);

      // 1x1 frame: latency from acceptance edge E to m_valid.
      mif.ready = 1'b1;
      fd0 = fd_n;
      start_frame(1, 1);
      chk("one_busy", busy, 1);
      send_pix({8'd255, 8'd0, 8'd0});
      repeat (3) @(posedge clk);
      #1;
      chk("one_mvalid_e3", mif.valid, 0);
      @(posedge clk);
      #1;
      chk("one_mvalid_e4", mif.valid, 1);
      chk("one_hsv", {m_h, m_s, m_v, m_sof, m_eol},
          {9'd0, 8'd255, 8'd255, 1'b1, 1'b1});
      wait_done("one_done");
      chk("one_fd_cnt", fd_n - fd0, 1);
      chk("one_idle", busy, 0);

      // 4x2 streamed; a start mid-frame must be ignored.
      fd0 = fd_n;
      o0 = out_n;
      start_frame(4, 2);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            cw = DW'(2);
            ch = DW'(1);
            start = 1'b1;
         end
         send_pix(pix(i, 11));
         start = 1'b0;
      end
      wait_done("f42_done");
      repeat (4) @(posedge clk);
      #1;
      chk("f42_outs", out_n - o0, 8);
      chk("f42_fd_cnt", fd_n - fd0, 1);
      chk("f42_sb_empty", q.size(), 0);

      // Backpressure: sink stalled for 20 cycles.
      mif.ready = 1'b0;
      o0 = out_n;
      start_frame(4, 4);
      a0 = acc_n;
      have_head = 1'b0;
      head = '0;
      fork
         send_frame(16, 77);
         begin
            repeat (20) begin
               @(negedge clk);
               if (mif.valid) begin
                  if (!have_head) begin
                     head = {m_h, m_s, m_v, m_sof, m_eol};
                     have_head = 1'b1;
                  end else begin
                     chk("bp_head_hold", {m_h, m_s, m_v, m_sof, m_eol}, head);
                  end
               end
            end
            chk("bp_accepted", acc_n - a0, FD);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_head_seen", have_head, 1);
            mif.ready = 1'b1;
         end
      join
      wait_done("bp_done");
      chk("bp_outs", out_n - o0, 16);
      chk("bp_sb_empty", q.size(), 0);

      // Exactly five credit stalls before the sink is released.
      mif.ready = 1'b0;
      o0 = out_n;
      start_frame(4, 2);
      s0 = stall_n;
      fork
         send_frame(8, 5);
         begin
            n = 0;
            while ((stall_n - s0) < 4 && n < 200) begin
               @(negedge clk);
               n++;
            end
            mif.ready = 1'b1;
         end
      join
      wait_done("st_done");
      chk("st_outs", out_n - o0, 8);
      chk("st_stalls_seen", stall_n - s0, 5);
`ifdef HSV_CTRL_STATS_EN
      chk("stat_pix", stat_pix, 8);
      chk("stat_stall", stat_stall, 5);
`else
      chk("stat_pix_off", stat_pix, 0);
      chk("stat_stall_off", stat_stall, 0);
`endif

      // Reset with three pixels inside the converter.
      fd0 = fd_n;
      start_frame(4, 2);
      send_frame(3, 9);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_m_valid", mif.valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", frame_done, 0);
      chk("mrst_s_ready", s_ready, 0);
      rst = 1'b1;
      o0 = out_n;
      repeat (10) @(posedge clk);
      #1;
      chk("mrst_no_out", out_n - o0, 0);
      chk("mrst_no_fd", fd_n - fd0, 0);
      fd0 = fd_n;
      start_frame(2, 2);
      send_frame(4, 123);
      wait_done("post_rst_done");
      chk("post_rst_outs", out_n - o0, 4);
      chk("post_rst_fd", fd_n - fd0, 1);
      chk("post_rst_sb", q.size(), 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/hsv_stream_ctrl.md
HSV_STREAM_CTRL -- requirements
Module: hsv_stream_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 3: converter latency in cycles from cvt_r/g/b change to matching cvt_h/s/v.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output buffer entries; must be at least PIPE_LAT+2.
REQ-003 SHALL have parameter DIM_W, default 12: width of frame dimension fields.
REQ-004 SHALL have port clk_Image_Process  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port Rst  in  1  reset; synchronous, active-low.
REQ-006 SHALL have ports start in 1 (frame start request), cfg_width in DIM_W, cfg_height in DIM_W (pixels per line, lines per frame).
REQ-007 SHALL have ports busy out 1 (frame in progress) and frame_done out 1 (one-cycle end-of-frame pulse).
REQ-008 SHALL have ports s_valid in 1, s_ready out 1, s_r/s_g/s_b in 8 each (input RGB pixel handshake).
REQ-009 SHALL have ports cvt_r/cvt_g/cvt_b out 8 each and cvt_h in 9, cvt_s in 8, cvt_v in 8 (drive/return of the free-running HSV converter).
REQ-010 SHALL have ports m_valid out 1, m_ready in 1, m_h out 9, m_s/m_v out 8, m_sof out 1, m_eol out 1 (output HSV stream).
REQ-011 SHALL have ports stat_pix out 32 and stat_stall out 32 (statistics; see Configuration).

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN; busy is high whenever state is not IDLE.
REQ-013 In IDLE, start=1 with cfg_width and cfg_height both nonzero SHALL latch both dimensions, clear x/y counters, and enter RUN on the next edge; start with either dimension zero is ignored.
REQ-014 start in RUN or DRAIN SHALL be ignored.
REQ-015 s_ready SHALL be 0 in IDLE and DRAIN; in RUN, s_ready is 1 iff FIFO occupancy plus in-flight pixels is less than FIFO_DEPTH (credit rule; the converter never stalls).
REQ-016 An accepted pixel (s_valid and s_ready on an edge) SHALL register s_r/g/b into cvt_r/g/b on that edge and push a tag {sof, eol} into a PIPE_LAT-deep tag shift register.
REQ-017 The tag SHALL be sof=1 when x=0 and y=0, and eol=1 when x=cfg_width-1; x wraps to 0 and y increments at eol.
REQ-018 PIPE_LAT edges after acceptance, cvt_h/s/v plus the tag SHALL be written into the FIFO; m_valid rises after edge E+PIPE_LAT+1 for acceptance edge E when the FIFO was empty.
REQ-019 Accepting the pixel with x=cfg_width-1 and y=cfg_height-1 SHALL move the state to DRAIN.
REQ-020 In DRAIN, when in-flight count is 0 and the FIFO is empty, the block SHALL pulse frame_done for one cycle and return to IDLE.
REQ-021 m_* SHALL present the FIFO head (show-ahead) and stay stable while m_valid=1 and m_ready=0.
REQ-022 A simultaneous FIFO write and read SHALL leave occupancy unchanged; the FIFO never overflows (REQ-015) and a read on empty is impossible (m_valid=0).

Reset
REQ-023 With Rst=0 at an edge, SHALL enter IDLE, clear counters, FIFO, and tags, and drive busy, frame_done, s_ready, m_valid, m_sof, m_eol, cvt_*, m_h/s/v, and stat_* to 0.
REQ-024 Reset during RUN or DRAIN SHALL discard in-flight pixels without a frame_done pulse.

Configuration
REQ-025 With HSV_CTRL_STATS_EN defined, stat_pix SHALL count m_valid and m_ready handshakes and stat_stall SHALL count RUN cycles with s_valid=1 and s_ready=0; both saturate at 2^32-1 and clear on an accepted start.
REQ-026 Without HSV_CTRL_STATS_EN, stat_pix and stat_stall SHALL be constant 0 and no counter logic is built.

Structure
REQ-027 The state enumeration and default parameter constants SHALL reside in package hsv_ctrl_pkg.
REQ-028 The output buffer SHALL be a sub-module hsv_ctrl_fifo (synchronous, show-ahead, width 27 = 9+8+8+sof+eol); the converter is instantiated outside this block.

Verification
REQ-029 Bench SHALL cover a 1x1 frame, RGB (255,0,0), m_ready=1: m_valid after edge E+4 with H=0, S=255, V=255, sof=1, eol=1; frame_done follows.
REQ-030 Bench SHALL cover a 4x2 frame streamed continuously: 8 outputs in order; sof on output 0 only; eol on outputs 3 and 7; exactly one frame_done.
REQ-031 Bench SHALL cover m_ready=0 for 20 cycles with s_valid=1: at most 8 pixels accepted, s_ready=0 afterwards, no data loss, and the m_* head is held stable.
REQ-032 Bench SHALL cover start with cfg_width=0: remain in IDLE with busy=0; start during RUN: no effect.
REQ-033 Bench SHALL cover Rst=0 asserted mid-frame with 3 pixels in flight: next cycle m_valid=0, busy=0, and no frame_done; a new frame then runs cleanly.
REQ-034 Bench SHALL cover, with HSV_CTRL_STATS_EN, a 4x2 frame with 5 backpressure stall cycles: stat_pix=8 and stat_stall=5.
